// File: rtl/rejection_sampler.sv
`timescale 1ns/1ps
// rejection_sampler
//   Draws pseudo-random candidate vectors from a 64-bit Galois LFSR, presents
//   them to an external constraint checker on cand_o, and forwards only the
//   candidates the checker marks as satisfied over a valid/ready stream.
//   A request aborts with a sticky fail flag once MAX_TRIES consecutive
//   rejects have been counted.
//
//   Optional build macro: SAMPLER_DEDUP_EN
//     When defined, the last accepted candidate is remembered and an identical
//     candidate in CHECK is rejected as if the checker had refused it.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; seed_load may reload the LFSR
//   GEN   | one LFSR word per cycle into cand_o, NWORDS cycles
//   CHECK | sat_i sampled against the complete candidate
//   HOLD  | accepted sample presented until sample_ready
module rejection_sampler #(
   parameter int VEC_W     = 506,
   parameter int MAX_TRIES = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             seed_load,
   input  logic [63:0]      seed,
   input  logic             start,
   input  logic [15:0]      req_count,
   output logic [VEC_W-1:0] cand_o,
   input  logic             sat_i,
   output logic             sample_valid,
   output logic [VEC_W-1:0] sample_data,
   input  logic             sample_ready,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [15:0]      attempts
);

   localparam int NWORDS = (VEC_W + 63) / 64;
   localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NWORDS - 1);
   localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
   localparam logic [16:0] TRY_LIMIT = 17'(MAX_TRIES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GEN   = 2'd1,
      S_CHECK = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t            state;
   logic [63:0]       lfsr;
   logic [63:0]       lfsr_next;
   logic [63:0]       seed_eff;
   logic [WIDX_W-1:0] word_idx;
   logic [15:0]       remaining;
   logic [16:0]       attempts_inc;
   logic [15:0]       attempts_sat;
   logic              accept;

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   assign seed_eff = (seed == 64'd0) ? 64'h1 : seed;

   // Widened increment so the budget compare cannot wrap at 16'hFFFF.
   assign attempts_inc = {1'b0, attempts} + 17'd1;
   assign attempts_sat = (attempts == 16'hFFFF) ? attempts : attempts_inc[15:0];

   // Galois right-shift step; taps fold back in when the bit shifted out is 1.
   always_comb begin
      lfsr_next = {1'b0, lfsr[63:1]};
      if (lfsr[0]) begin
         lfsr_next = lfsr_next ^ LFSR_TAPS;
      end
   end

`ifdef SAMPLER_DEDUP_EN
   logic [VEC_W-1:0] last_acc;
   logic             last_acc_vld;
   logic             is_dup;

   assign is_dup = last_acc_vld && (cand_o == last_acc);
   assign accept = sat_i && !is_dup;

   // Remember the most recent accepted candidate; a new request forgets it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_acc     <= '0;
         last_acc_vld <= 1'b0;
      end else if (state == S_IDLE && start) begin
         last_acc_vld <= 1'b0;
      end else if (state == S_CHECK && accept) begin
         last_acc     <= cand_o;
         last_acc_vld <= 1'b1;
      end
   end
`else
   assign accept = sat_i;
`endif

   // Candidate assembly: each GEN cycle drops the current LFSR word into slot word_idx;
   // the top word is truncated at VEC_W-1. Outside GEN the candidate holds.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cand_o <= '0;
      end else if (state == S_GEN) begin
         for (int b = 0; b < VEC_W; b++) begin
            if ((b / 64) == int'(word_idx)) begin
               cand_o[b] <= lfsr[6'(b % 64)];
            end
         end
      end
   end

   // Sequencer: request bookkeeping, LFSR stepping, accept/reject decisions and stream outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         lfsr         <= 64'h1;
         word_idx     <= '0;
         remaining    <= '0;
         attempts     <= '0;
         sample_valid <= 1'b0;
         sample_data  <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         fail         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               // Seed is loaded in the same edge as start, so GEN already sees it.
               if (seed_load) begin
                  lfsr <= seed_eff;
               end
               if (start) begin
                  if (req_count == 16'd0) begin
                     done <= 1'b1;
                  end else begin
                     fail      <= 1'b0;
                     attempts  <= '0;
                     remaining <= req_count;
                     word_idx  <= '0;
                     busy      <= 1'b1;
                     state     <= S_GEN;
                  end
               end
            end

            S_GEN: begin
               lfsr <= lfsr_next;
               if (word_idx == LAST_WORD) begin
                  word_idx <= '0;
                  state    <= S_CHECK;
               end else begin
                  word_idx <= word_idx + WIDX_W'(1);
               end
            end

            S_CHECK: begin
               if (accept) begin
                  sample_data  <= cand_o;
                  sample_valid <= 1'b1;
                  state        <= S_HOLD;
               end else begin
                  attempts <= attempts_sat;
                  if (attempts_inc == TRY_LIMIT) begin
                     fail  <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     state <= S_GEN;
                  end
               end
            end

            S_HOLD: begin
               if (sample_ready) begin
                  sample_valid <= 1'b0;
                  attempts     <= '0;
                  remaining    <= remaining - 16'd1;
                  if (remaining == 16'd1) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     state <= S_GEN;
                  end
               end
            end

            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rejection_sampler.sv
`timescale 1ns/1ps
// Testbench for rejection_sampler: a table of request scenarios checked against
// an LFSR reference model, plus hand sequences for reset mid-GEN and for
// duplicate handling on a narrow instance.
module tb_rejection_sampler;

   localparam int VEC_W    = 506;
   localparam int NWORDS   = (VEC_W + 63) / 64;
   localparam int MAXT     = 4;
   localparam int SM_W     = 4;
   localparam int SM_TRIES = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance
   logic             rst_n, seed_load, start, sample_ready, sat_i;
   logic [63:0]      seed;
   logic [15:0]      req_count;
   logic [VEC_W-1:0] cand_o, sample_data;
   logic             sample_valid, busy, done, fail;
   logic [15:0]      attempts;
   int               sat_mode;

   assign sat_i = (sat_mode == 1);

   rejection_sampler #(.VEC_W(VEC_W), .MAX_TRIES(MAXT)) dut (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .start(start),
      .req_count(req_count), .cand_o(cand_o), .sat_i(sat_i), .sample_valid(sample_valid),
      .sample_data(sample_data), .sample_ready(sample_ready), .busy(busy), .done(done),
      .fail(fail), .attempts(attempts)
   );

   // narrow instance: checker stub accepts only candidate value 0
   logic            sm_seed_load, sm_start, sm_ready, sm_sat;
   logic [63:0]     sm_seed;
   logic [15:0]     sm_req;
   logic [SM_W-1:0] sm_cand, sm_data;
   logic            sm_valid, sm_busy, sm_done, sm_fail;
   logic [15:0]     sm_attempts;

   assign sm_sat = (sm_cand == 4'h0);

   rejection_sampler #(.VEC_W(SM_W), .MAX_TRIES(SM_TRIES)) dut_sm (
      .clk(clk), .rst_n(rst_n), .seed_load(sm_seed_load), .seed(sm_seed), .start(sm_start),
      .req_count(sm_req), .cand_o(sm_cand), .sat_i(sm_sat), .sample_valid(sm_valid),
      .sample_data(sm_data), .sample_ready(sm_ready), .busy(sm_busy), .done(sm_done),
      .fail(sm_fail), .attempts(sm_attempts)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // reference LFSR model
   logic [63:0] m_lfsr;

   function automatic logic [63:0] lfsr_step(input logic [63:0] s);
      logic [63:0] r;
      r = {1'b0, s[63:1]};
      if (s[0]) r = r ^ 64'hD800000000000000;
      return r;
   endfunction

   function automatic logic [VEC_W-1:0] next_cand();
      logic [NWORDS*64-1:0] w;
      for (int k = 0; k < NWORDS; k++) begin
         w[k*64 +: 64] = m_lfsr;
         m_lfsr = lfsr_step(m_lfsr);
      end
      return w[VEC_W-1:0];
   endfunction

   typedef struct {
      logic [63:0] seed;
      int          req;
      int          sat;
      int          stall;
      int          n_valid;
      int          first_t;
      int          gap;
      int          end_t;
      logic        exp_done;
      logic        end_fail;
      int          end_att;
      logic        busy_seen;
   } vec_t;

   vec_t             vecs[6];
   logic [VEC_W-1:0] run_first;
   logic [VEC_W-1:0] ref0;

   // One request: seed_load and start in the same cycle, then watch until done or abort.
   task automatic run_vec(input vec_t v, input string tag);
      logic [VEC_W-1:0] exp_c, held;
      int nv, first_t, last_t, end_t, stall_left;
      logic done_seen, busy_seen, prev_valid;
      sat_mode = v.sat;
      m_lfsr   = (v.seed == 64'd0) ? 64'h1 : v.seed;
      @(negedge clk);
      seed = v.seed; seed_load = 1'b1; start = 1'b1;
      req_count = 16'(v.req); sample_ready = 1'b1;
      @(negedge clk);
      seed_load = 1'b0; start = 1'b0;
      nv = 0; first_t = -1; last_t = -1; end_t = -1; stall_left = v.stall;
      done_seen = 1'b0; busy_seen = 1'b0; prev_valid = 1'b0; held = '0;
      for (int t = 0; t < 200; t++) begin
         if (t == 0 && v.req > 0) check({tag, "_fail_cleared"}, 512'(fail), 512'(0));
         if (busy) busy_seen = 1'b1;
         if (sample_valid && !prev_valid) begin
            exp_c = next_cand();
            check({tag, "_sample_data"}, 512'(sample_data), 512'(exp_c));
            check({tag, "_cand_o"}, 512'(cand_o), 512'(exp_c));
            if (nv == 0) begin
               first_t   = t;
               run_first = sample_data;
            end else begin
               check({tag, "_gap"}, 512'(t - last_t), 512'(v.gap));
            end
            last_t = t;
            held   = sample_data;
            nv++;
         end else if (sample_valid) begin
            check({tag, "_data_stable"}, 512'(sample_data), 512'(held));
            check({tag, "_cand_stable"}, 512'(cand_o), 512'(held));
         end
         prev_valid = sample_valid;
         if (done) done_seen = 1'b1;
         if (done || (fail && !busy)) begin
            end_t = t;
            break;
         end
         if (sample_valid && stall_left > 0) begin
            sample_ready = 1'b0;
            stall_left--;
         end else begin
            sample_ready = 1'b1;
         end
         @(negedge clk);
      end
      check({tag, "_end_t"}, 512'(end_t), 512'(v.end_t));
      check({tag, "_n_valid"}, 512'(nv), 512'(v.n_valid));
      check({tag, "_first_t"}, 512'(first_t), 512'(v.first_t));
      check({tag, "_done"}, 512'(done_seen), 512'(v.exp_done));
      check({tag, "_fail"}, 512'(fail), 512'(v.end_fail));
      check({tag, "_attempts"}, 512'(attempts), 512'(v.end_att));
      check({tag, "_busy_seen"}, 512'(busy_seen), 512'(v.busy_seen));
      sample_ready = 1'b1;
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 512'(done), 512'(0));
      check({tag, "_idle_busy"}, 512'(busy), 512'(0));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] anchor;
      int sv_t[$];
      logic [SM_W-1:0] sv_d[$];
      int sm_end_t, sm_att_first;
      logic sm_done_seen;

      //        seed                    req sat stl nv first gap end done fail att busy
      vecs[0] = '{64'h1,                 3,  1,  0,  3,  9,  10, 30, 1'b1, 1'b0, 0, 1'b1};
      vecs[1] = '{64'h0,                 3,  1,  0,  3,  9,  10, 30, 1'b1, 1'b0, 0, 1'b1};
      vecs[2] = '{64'h0123456789ABCDEF,  1,  0,  0,  0, -1,   0, 36, 1'b0, 1'b1, 4, 1'b1};
      vecs[3] = '{64'h1,                 2,  1,  5,  2,  9,  15, 25, 1'b1, 1'b0, 0, 1'b1};
      vecs[4] = '{64'h0123456789ABCDEF,  2,  1,  0,  2,  9,  10, 20, 1'b1, 1'b0, 0, 1'b1};
      vecs[5] = '{64'h1,                 0,  1,  0,  0, -1,   0,  0, 1'b1, 1'b0, 0, 1'b0};

      rst_n = 1'b0; seed_load = 1'b0; start = 1'b0; sample_ready = 1'b1;
      seed = '0; req_count = '0; sat_mode = 0;
      sm_seed_load = 1'b0; sm_start = 1'b0; sm_ready = 1'b1; sm_seed = '0; sm_req = '0;
      run_first = '0; ref0 = '0;
      repeat (3) @(negedge clk);
      check("reset_valid", 512'(sample_valid), 512'(0));
      check("reset_busy", 512'(busy), 512'(0));
      check("reset_done", 512'(done), 512'(0));
      check("reset_fail", 512'(fail), 512'(0));
      check("reset_attempts", 512'(attempts), 512'(0));
      check("reset_cand", 512'(cand_o), 512'(0));
      check("reset_data", 512'(sample_data), 512'(0));
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i], $sformatf("v%0d", i));
         if (i == 0) ref0 = run_first;
         if (i == 1) check("seed0_equals_seed1", 512'(run_first), 512'(ref0));
      end

      // seed 1 expands to words 1, D8.., 6C.., 36.. at the bottom of the first candidate
      anchor = {64'h3600000000000000, 64'h6C00000000000000, 64'hD800000000000000, 64'h1};
      check("seed1_first_words", 512'(ref0[255:0]), 512'(anchor));

      // reset asserted while GEN is on word 3, then a clean rerun
      sat_mode = 1;
      @(negedge clk);
      seed = 64'h1; seed_load = 1'b1; start = 1'b1; req_count = 16'd1;
      @(negedge clk);
      seed_load = 1'b0; start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_reset_word0", 512'(cand_o[63:0]), 512'(64'h1));
      check("pre_reset_busy", 512'(busy), 512'(1));
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rst_mid_valid", 512'(sample_valid), 512'(0));
         check("rst_mid_cand", 512'(cand_o), 512'(0));
         check("rst_mid_busy", 512'(busy), 512'(0));
      end
      rst_n = 1'b1;
      run_vec(vecs[0], "rst_rerun");
      check("rst_rerun_first", 512'(run_first), 512'(ref0));

      // narrow instance: candidates from seed 1 are 1, 0, 0, 0, ...
      @(negedge clk);
      sm_seed = 64'h1; sm_seed_load = 1'b1; sm_start = 1'b1; sm_req = 16'd2; sm_ready = 1'b1;
      @(negedge clk);
      sm_seed_load = 1'b0; sm_start = 1'b0;
      sm_end_t = -1; sm_done_seen = 1'b0; sm_att_first = -1;
      for (int t = 0; t < 60; t++) begin
         if (sm_valid) begin
            if (sv_t.size() == 0) sm_att_first = int'(sm_attempts);
            sv_t.push_back(t);
            sv_d.push_back(sm_data);
         end
         if (sm_done) sm_done_seen = 1'b1;
         if (sm_done || (sm_fail && !sm_busy)) begin
            sm_end_t = t;
            break;
         end
         @(negedge clk);
      end
      check("sm_first_valid_t", 512'((sv_t.size() > 0) ? sv_t[0] : -1), 512'(4));
      check("sm_first_data", 512'((sv_d.size() > 0) ? sv_d[0] : 4'hF), 512'(0));
      check("sm_attempts_at_accept", 512'(sm_att_first), 512'(1));
`ifdef SAMPLER_DEDUP_EN
      check("sm_n_valid", 512'(sv_t.size()), 512'(1));
      check("sm_end_t", 512'(sm_end_t), 512'(9));
      check("sm_fail", 512'(sm_fail), 512'(1));
      check("sm_done", 512'(sm_done_seen), 512'(0));
      check("sm_attempts", 512'(sm_attempts), 512'(2));
`else
      check("sm_n_valid", 512'(sv_t.size()), 512'(2));
      check("sm_second_valid_t", 512'((sv_t.size() > 1) ? sv_t[1] : -1), 512'(7));
      check("sm_second_data", 512'((sv_d.size() > 1) ? sv_d[1] : 4'hF), 512'(0));
      check("sm_end_t", 512'(sm_end_t), 512'(8));
      check("sm_fail", 512'(sm_fail), 512'(0));
      check("sm_done", 512'(sm_done_seen), 512'(1));
      check("sm_attempts", 512'(sm_attempts), 512'(0));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rejection_sampler.md
Name: rejection_sampler

Overview:
Upstream candidate generator for a generated constraint checker. It draws pseudo-random candidate vectors from a 64-bit LFSR and drives them onto the checker's packed variable inputs. It samples the checker's single satisfied flag and forwards only accepted candidates downstream over a valid/ready stream. The block counts rejected candidates and aborts a request when a consecutive-reject budget runs out.

Parameters:
VEC_W, 506, total packed width of all checker variables; var_0 sits at the LSBs and each later var_N is packed above it.
MAX_TRIES, 1024, number of consecutive rejects allowed per sample before abort; legal range 1..65535.
NWORDS, (VEC_W+63)/64, derived value, not overridable; number of LFSR words per candidate.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous, active-low reset
seed_load  in  1  in IDLE, loads seed into the LFSR
seed  in  64  LFSR seed
start  in  1  single-cycle request pulse
req_count  in  16  number of accepted samples to produce
cand_o  out  VEC_W  candidate vector driven to the checker
sat_i  in  1  checker's all-constraints-satisfied flag, combinational from cand_o
sample_valid  out  1  accepted sample available
sample_data  out  VEC_W  accepted sample
sample_ready  in  1  downstream accepts the sample
busy  out  1  request in progress
done  out  1  one-cycle pulse when req_count samples have been delivered
fail  out  1  sticky flag: reject budget exhausted
attempts  out  16  rejects since the last accept, or since start

Behaviour:
- Reset (rst_n=0 at a clk edge) has priority over everything else and applies from any state, including mid-GEN or HOLD. State goes to IDLE and the LFSR is set to 64'h1. cand_o, sample_data, attempts and the remaining counter go to 0. sample_valid, busy, done and fail go to 0.
- LFSR: 64-bit Galois, right shift. When the LSB is 1, XOR the shifted value with 64'hD800000000000000. Loading a seed of 0 loads 64'h1 instead. The LFSR advances exactly once per GEN cycle and holds in every other state.
- State IDLE:
  - seed_load=1 loads seed.
  - start=1 with req_count=0: done pulses the next cycle and state stays IDLE.
  - start=1 with req_count>0: clears fail and attempts, sets remaining=req_count, goes to GEN.
  - If seed_load and start are both high in the same cycle, the seed is loaded first and generation uses the new seed.
- State GEN, NWORDS cycles, word index k = 0..NWORDS-1:
  - cand_o[64k+63:64k] takes the current LFSR value, truncated at bit VEC_W-1; then the LFSR steps.
  - After word NWORDS-1, go to CHECK.
- State CHECK, 1 cycle: sample sat_i against the now-complete cand_o.
  - sat_i=1: sample_data takes cand_o, sample_valid goes to 1, state goes to HOLD.
  - sat_i=0 and attempts+1 == MAX_TRIES: attempts is incremented, fail goes to 1, state goes to IDLE. done does not pulse.
  - sat_i=0 otherwise: attempts is incremented and state returns to GEN.
- State HOLD:
  - sample_valid=1 and sample_data is stable until a cycle with sample_ready=1.
  - On that handshake: sample_valid goes to 0, attempts goes to 0, remaining is decremented.
  - If remaining was 1: done pulses and state goes to IDLE. Otherwise state goes to GEN.
- Timing:
  - busy=1 in GEN, CHECK and HOLD.
  - start is ignored while busy.
  - Per-candidate latency is NWORDS+1 cycles, which is 9 for the default VEC_W. sample_valid rises NWORDS+1 cycles after the start edge when sat_i=1.
- attempts saturates at 16'hFFFF and never wraps.
- cand_o holds its value outside GEN.

Optional Feature:
SAMPLER_DEDUP_EN:
- When defined, the block keeps a last_accepted register of VEC_W bits plus a valid bit. The valid bit is cleared by reset and by start.
- In CHECK, a candidate equal to last_accepted, while its valid bit is set, is treated as sat_i=0 and counts against MAX_TRIES.
- On each accept, last_accepted is updated.
- When the macro is undefined, there is no register and no comparison, and duplicates are forwarded as-is.

Test Plan:
1. seed=64'h1 loaded, sat_i tied 1, req_count=3, sample_ready tied 1 -> sample_valid pulses at cycles 9, 19 and 29 after start; done pulses the cycle after the third handshake; attempts stays 0; fail stays 0.
2. sat_i tied 0, MAX_TRIES=4, req_count=1 -> fail=1 and attempts=4 after 36 cycles; state is back in IDLE; done never pulses; a new start clears fail.
3. sat_i tied 1, sample_ready held 0 for 5 cycles after sample_valid rises -> sample_data is unchanged, the LFSR does not advance, and the next candidate equals the one from a run with no stalls.
4. seed=0 versus seed=64'h1 in separate runs -> identical cand_o sequences; req_count=0 -> single done pulse and busy never rises.
5. rst_n driven low during GEN word 3, then released and start issued with the same seed reloaded -> outputs match a clean run, and no sample_valid occurs during the reset.
6. SAMPLER_DEDUP_EN defined, checker stub that accepts only value A, MAX_TRIES=2 -> the first sample is A; the second request for A is rejected and the attempts count reflects the duplicate rejection.
